// File: rtl/id_sequencer.sv
// Instruction-ID sequencer: issues one registered 7-bit ID per execute cycle and
// owns the reset sequence, memory/IO holds, branch bubbles and halt/resume.
module id_sequencer #(
  parameter int         RESET_CYCLES = 2,
  parameter int         MEM_CYCLES   = 2,
  parameter logic [6:0] NOP_ID       = 7'd74
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] decoded_id,
  input  logic       fetch_valid,
  output logic       fetch_ready,
  input  logic       take,
  input  logic       enable,
  input  logic       resume,
  output logic [6:0] ID,
  output logic       flush,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshake: decoded_id is consumed on a rising edge where fetch_valid and
  // fetch_ready are both high; fetch_ready depends only on the current state,
  // never on fetch_valid, and fetch_valid is ignored while fetch_ready is low.

  localparam logic [6:0] ID_RESET = 7'd100;
  localparam logic [6:0] ID_HALT  = 7'd75;
  localparam logic [6:0] ID_BR_A  = 7'd38;
  localparam logic [6:0] ID_BR_B  = 7'd73;
  localparam logic [6:0] ID_MAX   = 7'd100;

  localparam int CNT_MAX = (RESET_CYCLES > MEM_CYCLES) ? RESET_CYCLES : MEM_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_RUN    = 3'd1,
    ST_MEM    = 3'd2,
    ST_BUBBLE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [6:0]    accept_id;

  function automatic logic [6:0] sanitize(input logic [6:0] d);
    return ((d == 7'd0) || (d > ID_MAX)) ? NOP_ID : d;
  endfunction

  function automatic logic is_mem(input logic [6:0] d);
    return ((d >= 7'd39) && (d <= 7'd55)) || ((d >= 7'd67) && (d <= 7'd72));
  endfunction

  function automatic logic is_branch(input logic [6:0] d);
    return (d == ID_BR_A) || (d == ID_BR_B);
  endfunction

  assign accept_id   = fetch_valid ? sanitize(decoded_id) : NOP_ID;
  assign fetch_ready = (state == ST_RUN);
  assign dbg_state   = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_RST;
      ID      <= ID_RESET;
      counter <= CW'(RESET_CYCLES - 1);
      flush   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_RST: begin
          if (counter == '0) begin
            state <= ST_RUN;
            ID    <= NOP_ID;
            busy  <= 1'b0;
          end else begin
            counter <= counter - CW'(1);
          end
        end

        ST_RUN: begin
          if ((ID == ID_HALT) && !enable) begin
            state <= ST_HALT;
            busy  <= 1'b1;
          end else if (is_branch(ID) && take) begin
            // The instruction accepted alongside the branch is dropped here.
            state <= ST_BUBBLE;
            ID    <= NOP_ID;
            flush <= 1'b1;
            busy  <= 1'b1;
          end else begin
            ID <= accept_id;
            if (is_mem(accept_id)) begin
              state   <= ST_MEM;
              counter <= CW'(MEM_CYCLES - 1);
              busy    <= 1'b1;
            end
          end
        end

        ST_MEM: begin
          // Fetch is stalled while holding, so the exit edge can only issue a NOP.
          if (counter == '0) begin
            state <= ST_RUN;
            ID    <= NOP_ID;
            busy  <= 1'b0;
          end else begin
            counter <= counter - CW'(1);
          end
        end

        ST_BUBBLE: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end

        ST_HALT: begin
          if (resume) begin
            state <= ST_RUN;
            ID    <= NOP_ID;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= ST_RST;
          ID      <= ID_RESET;
          counter <= CW'(RESET_CYCLES - 1);
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule
